// File: rtl/fifo_pkg.sv
// Shared definitions for the synchronous FIFO and its read-side burst master.
package fifo_pkg;

  localparam int DT_WIDTH_DEF  = 8;
  localparam int LEN_WIDTH_DEF = 5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/skid_buf2.sv
// Two-entry output buffer between the FIFO read port and a valid/ready stream.
// An arriving word falls straight through to the output when the buffer is empty.
module skid_buf2 #(
  parameter int DT_WIDTH = 8
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                push_i,
  input  logic [DT_WIDTH-1:0] push_data_i,
  input  logic                ready_i,
  output logic                valid_o,
  output logic [DT_WIDTH-1:0] data_o,
  output logic [1:0]          count_o
);

  logic [DT_WIDTH-1:0] mem_q [2];
  logic                rd_ptr_q, rd_ptr_d;
  logic                wr_ptr_q, wr_ptr_d;
  logic [1:0]          count_q, count_d;
  logic                has_data;
  logic                fire;
  logic                store;
  logic                deq;

  assign has_data = (count_q != 2'd0);
  assign valid_o  = has_data | push_i;
  assign data_o   = (!has_data && push_i) ? push_data_i : mem_q[rd_ptr_q];
  assign count_o  = count_q;

  assign fire  = valid_o & ready_i;
  // a word consumed in the cycle it arrives into an empty buffer is never stored
  assign store = push_i & ~(~has_data & ready_i);
  assign deq   = has_data & ready_i;

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q + {1'b0, push_i} - {1'b0, fire};
    if (store) wr_ptr_d = ~wr_ptr_q;
    if (deq)   rd_ptr_d = ~rd_ptr_q;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (store) mem_q[wr_ptr_q] <= push_data_i;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/fifo_burst_reader.sv
// Drains cmd_len words from the FIFO read port onto a back-pressurable stream.
//   state | meaning
//   IDLE  | waiting for cmd_start
//   RUN   | issuing reads and delivering words until the burst is delivered
//   DONE  | one-cycle completion pulse, returns to IDLE
module fifo_burst_reader
  import fifo_pkg::*;
#(
  parameter int DT_WIDTH  = DT_WIDTH_DEF,
  parameter int LEN_WIDTH = LEN_WIDTH_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cmd_start,
  input  logic [LEN_WIDTH-1:0] cmd_len,
  output logic                 busy,
  output logic                 done,
  output logic                 rd_en,
  input  logic [DT_WIDTH-1:0]  rd_dt,
  input  logic                 f_empty,
  output logic                 out_valid,
  output logic [DT_WIDTH-1:0]  out_data,
  input  logic                 out_ready
);

  state_e               state_q, state_d;
  logic [LEN_WIDTH-1:0] issue_q, issue_d;
  logic [LEN_WIDTH-1:0] deliv_q, deliv_d;
  logic                 in_flight_q;
  logic [1:0]           buf_count;
  logic                 xfer;
  logic [2:0]           credit_level;

  skid_buf2 #(
    .DT_WIDTH (DT_WIDTH)
  ) u_buf (
    .clk_i       (clk),
    .rst_ni      (rst),
    .push_i      (in_flight_q),
    .push_data_i (rd_dt),
    .ready_i     (out_ready),
    .valid_o     (out_valid),
    .data_o      (out_data),
    .count_o     (buf_count)
  );

  assign xfer = out_valid & out_ready;

  // slots already claimed once this cycle's transfer has left the buffer
  assign credit_level = {1'b0, buf_count} + {2'b00, in_flight_q} - {2'b00, xfer};

  assign rd_en = (state_q == RUN) && (issue_q != '0) && !f_empty && (credit_level < 3'd2);
  assign busy  = (state_q != IDLE);
  assign done  = (state_q == DONE);

  always_comb begin
    state_d = state_q;
    issue_d = issue_q;
    deliv_d = deliv_q;
    case (state_q)
      IDLE: begin
        if (cmd_start) begin
          if (cmd_len != '0) begin
            state_d = RUN;
            issue_d = cmd_len;
            deliv_d = cmd_len;
          end else begin
            state_d = DONE;
          end
        end
      end
      RUN: begin
        if (rd_en) issue_d = issue_q - 1'b1;
        if (xfer && (deliv_q != '0)) begin
          deliv_d = deliv_q - 1'b1;
          if (deliv_q == LEN_WIDTH'(1)) state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      issue_q     <= '0;
      deliv_q     <= '0;
      in_flight_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      issue_q     <= issue_d;
      deliv_q     <= deliv_d;
      in_flight_q <= rd_en;
    end
  end

endmodule

// File: tb/tb_fifo_burst_reader.sv
// Directed bench for fifo_burst_reader with a behavioural 1-cycle-latency FIFO model.
module tb_fifo_burst_reader;

  logic       clk = 1'b0;
  logic       rst;
  logic       cmd_start;
  logic [4:0] cmd_len;
  logic       busy, done, rd_en;
  logic [7:0] rd_dt = 8'h00;
  logic       f_empty;
  logic       out_valid;
  logic [7:0] out_data;
  logic       out_ready;

  int checks = 0;
  int errors = 0;

  logic [7:0] fmem [0:63];
  int wr_ptr = 0;
  int rd_ptr = 0;

  logic [7:0] got [$];
  int rd_cnt = 0;
  int done_cnt = 0;
  int got_at_done = 0;
  int outstanding = 0;

  int base, rb, db;
  logic [7:0] exp_rd, exp_v, exp_done, exp_busy;

  always #5 clk = ~clk;

  fifo_burst_reader dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_start (cmd_start),
    .cmd_len   (cmd_len),
    .busy      (busy),
    .done      (done),
    .rd_en     (rd_en),
    .rd_dt     (rd_dt),
    .f_empty   (f_empty),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready)
  );

  assign f_empty = (wr_ptr == rd_ptr);

  always @(posedge clk) begin
    if (rd_en) begin
      rd_dt  <= fmem[rd_ptr[5:0]];
      rd_ptr <= rd_ptr + 1;
    end
  end

  // stream monitor, sampled after the driver has settled this cycle's inputs
  always begin
    @(negedge clk);
    #2;
    if (!rst) begin
      outstanding = 0;
    end else begin
      checks++;
      assert (!(rd_en && f_empty)) else begin
        errors++;
        $error("FAIL rd_en_while_empty observed=1 expected=0");
      end
      if (out_valid && out_ready) begin
        got.push_back(out_data);
        outstanding--;
      end
      if (rd_en) begin
        rd_cnt++;
        outstanding++;
        checks++;
        assert (outstanding <= 2) else begin
          errors++;
          $error("FAIL buffer_credit observed=%0d expected<=2", outstanding);
        end
      end
      if (done) begin
        done_cnt++;
        got_at_done = got.size();
      end
    end
  end

  task automatic cyc();
    @(negedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] v);
    fmem[wr_ptr[5:0]] = v;
    wr_ptr = wr_ptr + 1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_words(input string tag, input int b, input int n, input logic [7:0] first);
    chk({tag, "_count"}, 32'(got.size() - b), 32'(n));
    if (got.size() >= b + n) begin
      for (int i = 0; i < n; i++) chk({tag, "_word"}, 32'(got[b + i]), 32'(first + 8'(i)));
    end
  endtask

  task automatic mark();
    base = got.size();
    rb   = rd_cnt;
    db   = done_cnt;
  endtask

  initial begin
    rst = 1'b0; cmd_start = 1'b0; cmd_len = 5'd0; out_ready = 1'b0;
    cyc();
    chk("rst_busy",      32'(busy),      32'd0);
    chk("rst_done",      32'(done),      32'd0);
    chk("rst_rd_en",     32'(rd_en),     32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data",  32'(out_data),  32'd0);
    rst = 1'b1;

    // basic burst, full throughput
    for (int i = 0; i < 5; i++) push(8'h10 + 8'(i));
    out_ready = 1'b1;
    cyc();
    mark();
    cmd_len = 5'd5; cmd_start = 1'b1;
    exp_rd = 8'b0001_1111; exp_v = 8'b0011_1110; exp_done = 8'b0100_0000; exp_busy = 8'b0111_1111;
    for (int k = 1; k <= 8; k++) begin
      cyc();
      cmd_start = 1'b0;
      chk("t1_rd_en",     32'(rd_en),     32'(exp_rd[k-1]));
      chk("t1_out_valid", 32'(out_valid), 32'(exp_v[k-1]));
      chk("t1_done",      32'(done),      32'(exp_done[k-1]));
      chk("t1_busy",      32'(busy),      32'(exp_busy[k-1]));
      if (exp_v[k-1]) chk("t1_out_data", 32'(out_data), 32'(8'h10 + 8'(k - 2)));
    end
    cyc();
    chk_words("t1", base, 5, 8'h10);
    chk("t1_done_cnt", 32'(done_cnt - db), 32'd1);

    // back-pressure
    for (int i = 0; i < 4; i++) push(8'h10 + 8'(i));
    out_ready = 1'b0;
    cyc();
    mark();
    cmd_len = 5'd4; cmd_start = 1'b1;
    cyc();
    cmd_start = 1'b0;
    for (int k = 2; k <= 4; k++) begin
      cyc();
      chk("t2_stall_valid", 32'(out_valid), 32'd1);
      chk("t2_stall_data",  32'(out_data),  32'h10);
    end
    chk("t2_rd_before_ready", 32'(rd_cnt - rb), 32'd2);
    chk("t2_rd_en_stalled",   32'(rd_en),       32'd0);
    cyc();
    out_ready = 1'b1;
    for (int k = 6; k <= 12; k++) cyc();
    chk_words("t2", base, 4, 8'h10);
    chk("t2_done_cnt", 32'(done_cnt - db), 32'd1);
    chk("t2_rd_cnt",   32'(rd_cnt - rb),   32'd4);

    // empty stall
    push(8'h20); push(8'h21);
    cyc();
    mark();
    cmd_len = 5'd4; cmd_start = 1'b1;
    cyc();
    cmd_start = 1'b0;
    cyc();
    cyc();
    chk("t3_rd_en_empty_c3", 32'(rd_en), 32'd0);
    cyc();
    chk("t3_rd_en_empty_c4", 32'(rd_en), 32'd0);
    cyc();
    chk("t3_rd_en_empty_c5", 32'(rd_en), 32'd0);
    push(8'h22); push(8'h23);
    for (int k = 6; k <= 12; k++) cyc();
    chk_words("t3", base, 4, 8'h20);
    chk("t3_done_cnt",      32'(done_cnt - db), 32'd1);
    chk("t3_done_after_4th", 32'(got_at_done), 32'(base + 4));

    // zero length
    cyc();
    mark();
    cmd_len = 5'd0; cmd_start = 1'b1;
    cyc();
    cmd_start = 1'b0;
    chk("t4_done",      32'(done),      32'd1);
    chk("t4_busy",      32'(busy),      32'd1);
    chk("t4_rd_en",     32'(rd_en),     32'd0);
    chk("t4_out_valid", 32'(out_valid), 32'd0);
    cyc();
    chk("t4_done_after", 32'(done), 32'd0);
    chk("t4_busy_after", 32'(busy), 32'd0);
    cyc();
    chk("t4_rd_cnt",   32'(rd_cnt - rb),   32'd0);
    chk("t4_done_cnt", 32'(done_cnt - db), 32'd1);

    // start while busy and in the DONE cycle
    for (int i = 0; i < 7; i++) push(8'h30 + 8'(i));
    cyc();
    mark();
    cmd_len = 5'd3; cmd_start = 1'b1;
    cyc();
    cmd_start = 1'b0;
    cyc();
    cmd_len = 5'd7; cmd_start = 1'b1;
    cyc();
    cmd_start = 1'b0;
    cyc();
    cyc();
    chk("t5_done", 32'(done), 32'd1);
    cmd_len = 5'd7; cmd_start = 1'b1;
    cyc();
    cmd_start = 1'b0;
    chk("t5_busy_c6", 32'(busy), 32'd0);
    cyc();
    chk("t5_busy_c7",  32'(busy),  32'd0);
    chk("t5_rd_en_c7", 32'(rd_en), 32'd0);
    for (int k = 8; k <= 10; k++) cyc();
    chk_words("t5", base, 3, 8'h30);
    chk("t5_done_cnt",  32'(done_cnt - db),   32'd1);
    chk("t5_rd_cnt",    32'(rd_cnt - rb),     32'd3);
    chk("t5_fifo_left", 32'(wr_ptr - rd_ptr), 32'd4);

    // reset mid-burst: word 0x33 is in flight and lost
    cyc();
    cmd_len = 5'd4; cmd_start = 1'b1;
    cyc();
    cmd_start = 1'b0;
    chk("t6_rd_en_c1", 32'(rd_en), 32'd1);
    cyc();
    rst = 1'b0;
    #1;
    chk("t6_rst_busy",      32'(busy),      32'd0);
    chk("t6_rst_done",      32'(done),      32'd0);
    chk("t6_rst_rd_en",     32'(rd_en),     32'd0);
    chk("t6_rst_out_valid", 32'(out_valid), 32'd0);
    chk("t6_rst_out_data",  32'(out_data),  32'd0);
    cyc();
    cyc();
    rst = 1'b1;
    cyc();
    mark();
    cmd_len = 5'd2; cmd_start = 1'b1;
    cyc();
    cmd_start = 1'b0;
    for (int k = 2; k <= 7; k++) cyc();
    chk_words("t6", base, 2, 8'h34);
    chk("t6_done_cnt",  32'(done_cnt - db),   32'd1);
    chk("t6_rd_cnt",    32'(rd_cnt - rb),     32'd2);
    chk("t6_fifo_left", 32'(wr_ptr - rd_ptr), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
